// File: rtl/mac_accum_4b_pkg.sv
// mac_pkg: shared types and defaults for the mac_accum_4b slice.
//   state_e        : block controller state (IDLE/RUN/DRAIN/DONE), 2 bits
//   *_DEF          : default ACC_W / MAX_TERMS / CNT_W for the top
//   OPER_W, PROD_W : multiplier operand and product widths
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int ACC_W_DEF     = 12;
  localparam int MAX_TERMS_DEF = 16;
  localparam int CNT_W_DEF     = 5;

  localparam int OPER_W = 4;
  localparam int PROD_W = 8;

endpackage

// File: rtl/mac_accum_4b_if.sv
// mac_accum_4b_if: bundles the operand stream, the external multiplier link
// and the result stream of mac_accum_4b.
//   in_*   : operand pair stream (valid/ready, in_last marks block end)
//   mul_*  : registered operands out, combinational product back
//   out_*  : block result stream (valid/ready)
// Modports: slave = the accumulator, master = producer/consumer/multiplier.
interface mac_accum_4b_if
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [OPER_W-1:0] in_a;
  logic [OPER_W-1:0] in_b;
  logic              in_last;

  logic [OPER_W-1:0] mul_a;
  logic [OPER_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_p;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_acc, out_count, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/mac_accum_4b.sv
// mac_accum_4b: streaming multiply-accumulate controller for an external
// 4x4 combinational multiplier.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : mac_accum_4b_if.slave (operand stream, multiplier link, result)
// Stage 1 (accept edge) registers operands onto mul_a/mul_b; stage 2 (next
// edge) adds the returned product into the accumulator. Back-to-back terms
// overlap the two stages, so throughput is one term per clock.
module mac_accum_4b
  import mac_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mac_accum_4b_if.slave   bus
);

  state_e            state_q, state_d;
  logic [OPER_W-1:0] mul_a_q, mul_a_d;
  logic [OPER_W-1:0] mul_b_q, mul_b_d;
  logic              pv_q, pv_d;       // product on mul_p belongs to a live term
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              eff_last;
  logic              drain_hs;
  logic [CNT_W:0]    n_after;
  logic [ACC_W:0]    sum;

  assign accept   = bus.in_valid && in_ready;
  assign drain_hs = out_valid && bus.out_ready;

  // cnt_q lags acceptance by one edge, so the term still in stage 2 (pv_q)
  // has to be added to get the count including the term being accepted.
  assign n_after  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pv_q} + {{CNT_W{1'b0}}, 1'b1};
  assign eff_last = bus.in_last || (n_after == (CNT_W+1)'(MAX_TERMS));

  // Carry out of bit ACC_W-1 is what flags overflow.
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(bus.mul_p);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = eff_last ? DRAIN : RUN;
      RUN:     if (accept && eff_last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready is forced low while reset is held, not just after it.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE, RUN: in_ready  = !reset;
      DONE:      out_valid = 1'b1;
      default:   ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    pv_d    = accept;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    // Operands hold when nothing is accepted; only pv drops.
    if (accept) begin
      mul_a_d = bus.in_a;
      mul_b_d = bus.in_b;
    end

    if (pv_q) begin
      acc_d = sum[ACC_W-1:0];
      cnt_d = cnt_q + CNT_W'(1);
      if (sum[ACC_W]) ovf_d = 1'b1;
    end

    // Result handed off: start the next block from a clean slate.
    if (drain_hs) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // -------------------------------------------------------------- outputs
  assign bus.in_ready  = in_ready;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.out_valid = out_valid;
  assign bus.out_acc   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: doc/mac_accum_4b.md
Name: mac_accum_4b

Overview:
Streaming multiply-accumulate controller that feeds a 4x4 combinational array multiplier and consumes its 8-bit product. Accepts a block of operand pairs over a valid/ready handshake, registers each pair onto the multiplier inputs, and accumulates the returned products. Presents the block sum with a term count and an overflow flag on a valid/ready output.

Parameters:
ACC_W, 12, accumulator and out_acc width in bits; must be at least 8.
MAX_TERMS, 16, maximum terms per block; a block is force-terminated at this count.
CNT_W, 5, term counter width; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
in_a  input  4  multiplicand
in_b  input  4  multiplier
in_last  input  1  this pair is the final term of the block
mul_a  output  4  registered operand driven to the external multiplier
mul_b  output  4  registered operand driven to the external multiplier
mul_p  input  8  multiplier product, combinational from mul_a and mul_b
out_valid  output  1  block result valid
out_ready  input  1  consumer accepts the result
out_acc  output  ACC_W  accumulated sum of products
out_count  output  CNT_W  number of terms in the block
out_ovf  output  1  sticky flag: the accumulator wrapped during this block

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: mul_a=0, mul_b=0, accumulator=0, count=0, ovf=0, pipeline-valid=0, state=IDLE, out_valid=0. in_ready is 0 during reset and 1 in the first cycle after reset.
- Accept: a term is accepted on an edge where in_valid && in_ready.
- States:
  - IDLE: in_ready=1, accumulator=0. Accepting a non-last term moves to RUN. Accepting a last term moves to DRAIN.
  - RUN: in_ready=1. The effective last condition is in_last, or count_after_accept == MAX_TERMS. Accepting an effective-last term moves to DRAIN.
  - DRAIN: in_ready=0. The pending product is added, then the state moves to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, the accumulator, count and ovf clear and the state moves to IDLE.
- Pipeline:
  - The accepting edge E0 loads mul_a/mul_b and sets pipeline-valid.
  - On edge E1, acc <= acc + zero-extended mul_p and count <= count+1.
  - Throughput is one term per clock; back-to-back accepts overlap stage 1 and stage 2.
  - When no term is accepted, mul_a/mul_b hold their values and pipeline-valid clears.
- Latency: out_valid rises in the cycle after E1, i.e. 2 clocks after the last term's accepting edge.
- Arithmetic: the sum is taken modulo 2^ACC_W. ovf is set on the edge where the addition carries out of bit ACC_W-1 and stays set until the result is handshaken out.
  - With default parameters overflow cannot occur (16*225=3600 < 4096).
- Output stability: out_acc, out_count and out_ovf hold stable while out_valid=1 && out_ready=0.
  - out_ready while out_valid=0 is ignored.
  - in_valid while in_ready=0 is ignored; its operands are not captured.
- Empty blocks do not exist. Every block holds at least one term.
- Reset mid-operation discards any in-flight term and any partial sum. There is no partial output.

Decomposition:
- Shared package mac_pkg holds:
  - state enum IDLE/RUN/DRAIN/DONE (2-bit)
  - default ACC_W, MAX_TERMS, CNT_W
  - OPER_W=4 and PROD_W=8
- No sub-module. The multiplier stays external and connects through mul_a/mul_b/mul_p so the same multiplier can be shared or swapped; the bench instantiates it.

Test Plan:
1. Single term a=3, b=5, in_last=1, out_ready=1 -> out_valid 2 clocks after accept; out_acc=15, out_count=1, out_ovf=0; back to IDLE with in_ready=1 next cycle.
2. Four back-to-back terms (15,15),(1,1),(2,3),(0,9), last on the 4th -> in_ready=1 for all four cycles then 0; out_acc=232, out_count=4.
3. 16 terms of 15x15, in_last never set -> 16th term forces the end, in_ready drops after it; out_acc=3600, out_count=16, out_ovf=0.
4. ACC_W=9, three terms of 15x15 -> out_acc=163 (675 mod 512), out_ovf=1. The next block, a single 1x1, gives out_acc=1 and out_ovf=0.
5. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid/out_acc stable, in_ready=0, no operand captured. After the handshake, the next block (2x2, last) gives out_acc=4.
6. reset=1 for one cycle in RUN after two accepted terms -> next cycle all outputs at reset values. A following block of 7x3 gives out_acc=21, out_count=1.
